// File: rtl/fifo_pack_flush.sv
// Narrow-entry FIFO that drains on flush as PACK-lane words, padding unused lanes; 2-cycle flush-to-valid, word held while rd_ready_i low.
// FIFO_FLUSH_AUTO_EN: self-start one full word whenever at least PACK entries are buffered.
module fifo_pack_flush #(
  parameter int                DATA_W  = 4,
  parameter int                DEPTH   = 32,
  parameter int                PACK    = 8,
  parameter logic [DATA_W-1:0] PAD_VAL = 4'hC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       flush_i,
  output logic                       flush_busy_o,
  output logic                       rd_valid_o,
  output logic [DATA_W*PACK-1:0]     rd_data_o,
  output logic [$clog2(PACK+1)-1:0]  rd_count_o,
  input  logic                       rd_ready_i,
  output logic                       flush_done_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(PACK + 1);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT, DONE} state_t;

  state_t                   state_q;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q, tgt_q;
  logic [PW-1:0]            wr_ptr_d, rd_ptr_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W*PACK-1:0]   rd_data_q, load_data;
  logic [CW-1:0]            rd_count_q, load_n;
  logic                     rd_valid_q, flush_done_q, auto_q;
  logic [PW-1:0]            level, avail;
  logic                     full, wr_en;
  logic [AW-1:0]            rd_idx;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == PW'(DEPTH));
  assign wr_en    = wr_valid_i && !full;
  assign wr_ptr_d = wr_ptr_q + PW'(1);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_count_q);

  assign wr_ready_o   = !full;
  assign full_o       = full;
  assign empty_o      = (level == '0);
  assign level_o      = LW'(level);
  assign flush_busy_o = (state_q != IDLE);
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign rd_count_o   = rd_count_q;
  assign flush_done_o = flush_done_q;

  // Entries still owed to this flush; never read past the target.
  assign avail  = tgt_q - rd_ptr_q;
  assign load_n = (avail >= PW'(PACK)) ? CW'(PACK) : CW'(avail);

  always_comb begin
    load_data = {PACK{PAD_VAL}};
    rd_idx    = '0;
    for (int i = 0; i < PACK; i++) begin
      rd_idx = rd_ptr_q[AW-1:0] + AW'(i);
      if (CW'(i) < load_n) begin
        load_data[i*DATA_W +: DATA_W] = mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      tgt_q        <= '0;
      rd_data_q    <= '0;
      rd_count_q   <= '0;
      rd_valid_q   <= 1'b0;
      flush_done_q <= 1'b0;
      auto_q       <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            tgt_q   <= wr_ptr_q;
            auto_q  <= 1'b0;
            state_q <= (level == '0) ? DONE : LOAD;
          end
`ifdef FIFO_FLUSH_AUTO_EN
          else if (level >= PW'(PACK)) begin
            tgt_q   <= rd_ptr_q + PW'(PACK);
            auto_q  <= 1'b1;
            state_q <= LOAD;
          end
`endif
        end
        LOAD: begin
          rd_data_q  <= load_data;
          rd_count_q <= load_n;
          rd_valid_q <= 1'b1;
          state_q    <= PRESENT;
        end
        PRESENT: begin
          if (rd_ready_i) begin
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= 1'b0;
            state_q    <= (rd_ptr_d == tgt_q) ? DONE : LOAD;
          end
        end
        DONE: begin
          flush_done_q <= !auto_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pack_flush.sv
// Randomised scoreboard bench for fifo_pack_flush (default build, auto-start disabled).
module tb_fifo_pack_flush;
  localparam int DEPTH = 32;
  localparam int PACK  = 8;
  localparam logic [3:0] PAD = 4'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid_i, flush_i, rd_ready_i;
  logic [3:0]  wr_data_i;
  logic        wr_ready_o, flush_busy_o, rd_valid_o, flush_done_o, empty_o, full_o;
  logic [31:0] rd_data_o;
  logic [3:0]  rd_count_o;
  logic [5:0]  level_o;

  always #5 clk = ~clk;

  fifo_pack_flush dut (
    .clk(clk), .reset(reset),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_count_o(rd_count_o),
    .rd_ready_i(rd_ready_i), .flush_done_o(flush_done_o),
    .empty_o(empty_o), .full_o(full_o), .level_o(level_o)
  );

  typedef struct { logic [31:0] dat; int cnt; } word_t;

  word_t      exp_q[$];
  logic [3:0] model_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the flushed entries in order, cut into PACK-sized words, remainder padded.
  task automatic build_words(input int n);
    word_t w;
    int    k;
    while (n > 0) begin
      k     = (n > PACK) ? PACK : n;
      w.dat = {8{PAD}};
      for (int i = 0; i < k; i++) w.dat[i*4 +: 4] = model_q.pop_front();
      w.cnt = k;
      exp_q.push_back(w);
      n -= k;
    end
  endtask

  initial begin : monitor
    logic        stall;
    logic [31:0] hold_d;
    logic [3:0]  hold_c;
    word_t       w;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && rd_valid_o) begin
        if (stall) begin
          chk("stall_data", rd_data_o, hold_d);
          chk("stall_count", rd_count_o, hold_c);
        end
        if (rd_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_word", rd_valid_o, 0);
          else begin
            w = exp_q.pop_front();
            chk("word_data", rd_data_o, w.dat);
            chk("word_count", rd_count_o, w.cnt);
          end
          stall = 1'b0;
        end else begin
          stall  = 1'b1;
          hold_d = rd_data_o;
          hold_c = rd_count_o;
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic idle_write(input logic [3:0] d);
    @(posedge clk); #1;
    chk("idle_level", level_o, model_q.size());
    chk("idle_wr_ready", wr_ready_o, model_q.size() < DEPTH);
    chk("idle_no_done", flush_done_o, 0);
    wr_valid_i = 1'b1; wr_data_i = d; flush_i = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    wr_valid_i = 1'b0; flush_i = 1'b0;
    chk({tag, "_level"}, level_o, model_q.size());
    chk({tag, "_empty"}, empty_o, model_q.size() == 0);
    chk({tag, "_full"}, full_o, model_q.size() == DEPTH);
    chk({tag, "_busy"}, flush_busy_o, 0);
  endtask

  function automatic logic next_rdy(input int mode, input int k);
    if (mode == 1) return 1'($urandom_range(1));
    if (mode == 2) return k >= 7;
    return 1'b1;
  endfunction

  task automatic run_flush(input int rdy_mode, input int wr_pct, input bit spur,
                           output int vld_lat, output int done_lat);
    int         n, k;
    bit         acc;
    logic [3:0] d;
    @(posedge clk); #1;
    d          = 4'($urandom);
    wr_valid_i = ($urandom_range(99) < wr_pct);
    wr_data_i  = d;
    acc        = wr_valid_i && (model_q.size() < DEPTH);
    n          = model_q.size();
    build_words(n);
    if (acc) model_q.push_back(d);
    flush_i    = 1'b1;
    rd_ready_i = next_rdy(rdy_mode, 0);
    vld_lat = -1; done_lat = -1; k = 0;
    while (done_lat < 0 && k < 300) begin
      @(negedge clk);
      k++;
      if (rd_valid_o && vld_lat < 0) vld_lat = k;
      if (flush_done_o) begin
        done_lat = k;
        flush_i  = 1'b0;
      end else begin
        @(posedge clk); #1;
        flush_i    = spur && flush_busy_o && ($urandom_range(7) == 0);
        d          = 4'($urandom);
        wr_valid_i = ($urandom_range(99) < wr_pct) && (model_q.size() + n < DEPTH);
        wr_data_i  = d;
        if (wr_valid_i) model_q.push_back(d);
        rd_ready_i = next_rdy(rdy_mode, k);
      end
    end
    chk("flush_done_seen", done_lat >= 0, 1);
    chk("words_drained_at_done", exp_q.size(), 0);
  endtask

  initial begin : stim
    int vl, dl, nw;
    reset = 1'b0; wr_valid_i = 1'b0; wr_data_i = '0; flush_i = 1'b0; rd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", wr_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rd_count", rd_count_o, 0);
    chk("rst_done", flush_done_o, 0);
    chk("rst_busy", flush_busy_o, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Three entries: one padded word.
    for (int i = 1; i <= 3; i++) idle_write(4'(i));
    run_flush(0, 0, 0, vl, dl);
    chk("small_vld_lat", vl, 3);
    chk("small_done_lat", dl, 5);
    idle_check("small");

    // Twenty entries: 8, 8, 4.
    for (int i = 0; i < 20; i++) idle_write(4'(i));
    run_flush(0, 0, 0, vl, dl);
    chk("multi_done_lat", dl, 9);
    idle_check("multi");

    // Fill to full, one dropped write, then drain four words.
    for (int i = 0; i < 33; i++) idle_write(4'(i + 5));
    idle_check("full");
    chk("full_wr_ready", wr_ready_o, 0);
    run_flush(0, 0, 0, vl, dl);
    chk("full_done_lat", dl, 11);
    idle_check("full_drained");

    // Empty flush.
    run_flush(0, 0, 0, vl, dl);
    chk("empty_no_word", vl, -1);
    chk("empty_done_lat", dl, 3);
    idle_check("empty_flush");

    // Consumer stalls five cycles; writes during the flush stay behind.
    for (int i = 0; i < 5; i++) idle_write(4'($urandom));
    run_flush(2, 60, 0, vl, dl);
    idle_check("stall");

    // Reset while a word is presented.
    for (int i = 0; i < 10; i++) idle_write(4'($urandom));
    @(posedge clk); #1;
    wr_valid_i = 1'b0; flush_i = 1'b1; rd_ready_i = 1'b0;
    @(posedge clk); #1 flush_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_valid", rd_valid_o, 1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("arst_rd_valid", rd_valid_o, 0);
    chk("arst_level", level_o, 0);
    chk("arst_busy", flush_busy_o, 0);
    chk("arst_empty", empty_o, 1);
    model_q.delete();
    #1 reset = 1'b1;
    idle_check("after_reset");

    // Random writes and flushes with random backpressure and ignored flush pulses.
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(40);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(3) == 0) begin
          @(posedge clk); #1 wr_valid_i = 1'b0;
        end
        idle_write(4'($urandom));
      end
      run_flush(1, 40, 1, vl, dl);
      idle_check("rand");
    end

    repeat (4) @(posedge clk);
    chk("final_no_pending_words", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
